// File: rtl/sensor_gpio_pkg.sv
// Shared types and helpers for the sensor GPIO input conditioner.
// Event records carry a timestamp sized for the widest supported counter.
package sensor_gpio_pkg;

    localparam int CHAN_W   = 3;
    localparam int TS_MAX_W = 32;

    typedef struct packed {
        logic [CHAN_W-1:0]   chan;
        logic                rise;
        logic [TS_MAX_W-1:0] ts;
    } sens_event_t;

    // Bits needed to count 0 .. cycles-1 (at least one bit).
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sensor_gpio_conditioner_debounce.sv
// One sensor channel: synchroniser chain, persistence counter and stable level.
// flip is asserted combinationally on the edge where stable is about to change.
module sensor_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    output logic stable,
    output logic flip,
    output logic level
);
    import sensor_gpio_pkg::*;

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   differs;

    assign level   = sync_q[SYNC_STAGES-1];
    assign differs = (level != stable);
    assign flip    = differs && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            if (flip) begin
                stable <= level;
                cnt    <= '0;
            end else if (differs) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sensor_gpio_conditioner.sv
// Debounces raw sensor pins onto the GPIO input bus and queues timestamped
// edge events (one pending slot per channel feeding a fall-through FIFO).
module sensor_gpio_conditioner
    import sensor_gpio_pkg::*;
#(
    parameter int NUM_CH          = 6,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int TS_WIDTH        = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [NUM_CH-1:0]   sens_in,
    output logic [NUM_CH-1:0]   sens_stable,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [CHAN_W-1:0]   ev_chan,
    output logic                ev_rise,
    output logic [TS_WIDTH-1:0] ev_ts,
    output logic                ev_overflow,
    input  logic                ovf_clr,
    output logic                irq
);

    localparam int               PTR_W   = cnt_width(FIFO_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [NUM_CH-1:0]   flip;
    logic [NUM_CH-1:0]   level;
    logic [TS_WIDTH-1:0] ts_cnt;

    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   pend_rise;
    logic [TS_WIDTH-1:0] pend_ts [NUM_CH];

    logic                sel_valid;
    logic [CHAN_W-1:0]   sel_chan;
    logic                sel_rise;
    logic [TS_WIDTH-1:0] sel_ts;

    sens_event_t         mem [FIFO_DEPTH];
    sens_event_t         head;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                push;
    logic                pop;
    logic                drop;
    logic                head_ts_unused;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sensor_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (aclk),
            .resetn (aresetn),
            .pin    (sens_in[g]),
            .stable (sens_stable[g]),
            .flip   (flip[g]),
            .level  (level[g])
        );
    end

    // Lowest-index pending channel wins; scanning downward lets it overwrite.
    always_comb begin
        sel_valid = 1'b0;
        sel_chan  = '0;
        sel_rise  = 1'b0;
        sel_ts    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_valid = 1'b1;
                sel_chan  = CHAN_W'(i);
                sel_rise  = pend_rise[i];
                sel_ts    = pend_ts[i];
            end
        end
    end

    assign push = sel_valid && (count < DEPTH_C);
    assign pop  = ev_valid && ev_ready;
    assign drop = |(flip & pending);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ts_cnt      <= '0;
            pending     <= '0;
            pend_rise   <= '0;
            ev_overflow <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_ts[i] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (flip[i] && !pending[i]) begin
                    pending[i]   <= 1'b1;
                    pend_rise[i] <= level[i];
                    pend_ts[i]   <= ts_cnt;
                end else if (push && (sel_chan == CHAN_W'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
            // A drop takes priority over a coincident clear request.
            if (drop) begin
                ev_overflow <= 1'b1;
            end else if (ovf_clr) begin
                ev_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= '{chan: sel_chan, rise: sel_rise, ts: TS_MAX_W'(sel_ts)};
        end
    end

    // Upper timestamp bits of the stored record are always zero.
    assign head           = mem[rd_ptr];
    assign head_ts_unused = ^head.ts;
    assign ev_valid       = (count != '0);
    assign ev_chan        = head.chan;
    assign ev_rise        = head.rise;
    assign ev_ts          = head.ts[TS_WIDTH-1:0];
    assign irq            = ev_valid | ev_overflow;

endmodule

// File: tb/tb_sensor_gpio_conditioner.sv
// Directed bench: stimulus pushes expected events into a queue, a negedge
// monitor pops and compares every accepted event.
module tb_sensor_gpio_conditioner;

    localparam int NUM_CH = 6;
    localparam int TS_W   = 8;

    logic              aclk;
    logic              aresetn;
    logic [NUM_CH-1:0] sens_in;
    logic [NUM_CH-1:0] sens_stable;
    logic              ev_valid;
    logic              ev_ready;
    logic [2:0]        ev_chan;
    logic              ev_rise;
    logic [TS_W-1:0]   ev_ts;
    logic              ev_overflow;
    logic              ovf_clr;
    logic              irq;

    typedef struct {
        logic [2:0]      chan;
        logic            rise;
        logic [TS_W-1:0] ts;
    } exp_t;

    exp_t            exp_q[$];
    logic [TS_W-1:0] tb_ts;
    int              n_checks = 0;
    int              n_fail   = 0;

    sensor_gpio_conditioner #(
        .NUM_CH          (NUM_CH),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .TS_WIDTH        (TS_W),
        .FIFO_DEPTH      (4)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .sens_in     (sens_in),
        .sens_stable (sens_stable),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_chan     (ev_chan),
        .ev_rise     (ev_rise),
        .ev_ts       (ev_ts),
        .ev_overflow (ev_overflow),
        .ovf_clr     (ovf_clr),
        .irq         (irq)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference free-running timestamp
    always @(posedge aclk) begin
        if (!aresetn) tb_ts <= '0;
        else          tb_ts <= tb_ts + 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Consume and verify every event the DUT hands over
    always @(negedge aclk) begin
        if (aresetn && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_event: got chan=%0d rise=%0d ts=%0d, expected none",
                         ev_chan, ev_rise, ev_ts);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("ev_chan", 32'(ev_chan), 32'(e.chan));
                checkOutput("ev_rise", 32'(ev_rise), 32'(e.rise));
                checkOutput("ev_ts",   32'(ev_ts),   32'(e.ts));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    // Drive a new pin pattern right after the next edge; a persisting change
    // surfaces as an event stamped five counts later (2 sync + 4 debounce - 1).
    task automatic applyStimulus(input logic [NUM_CH-1:0] value, input bit expect_events);
        logic [NUM_CH-1:0] changed;
        logic [TS_W-1:0]   t;
        exp_t              e;
        @(posedge aclk);
        #1;
        changed = value ^ sens_in;
        t       = tb_ts + 8'd5;
        sens_in = value;
        if (expect_events) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (changed[i]) begin
                    e.chan = 3'(i);
                    e.rise = value[i];
                    e.ts   = t;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic doReset();
        sens_in = '0;
        ovf_clr = 1'b0;
        aresetn = 1'b0;
        tick(2);
        exp_q.delete();
        aresetn = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int limit);
        for (int k = 0; k < limit && (exp_q.size() != 0 || ev_valid); k++) tick(1);
        checkOutput(name, 32'(exp_q.size()), 32'd0);
        checkOutput({name, "_valid"}, 32'(ev_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sens_in  = '0;
        ev_ready = 1'b1;
        ovf_clr  = 1'b0;
        aresetn  = 1'b0;
        doReset();
        checkOutput("reset_stable", 32'(sens_stable), 32'd0);
        checkOutput("reset_valid",  32'(ev_valid),    32'd0);
        checkOutput("reset_irq",    32'(irq),         32'd0);
        checkOutput("reset_ovf",    32'(ev_overflow), 32'd0);

        $display("[TB] single rising edge on channel 2");
        applyStimulus(6'b000100, 1'b1);
        tick(5);
        checkOutput("latency_stable_early", 32'(sens_stable), 32'd0);
        tick(1);
        checkOutput("latency_stable", 32'(sens_stable), 32'b000100);
        checkOutput("latency_valid_early", 32'(ev_valid), 32'd0);
        tick(1);
        checkOutput("latency_valid", 32'(ev_valid), 32'd1);
        checkOutput("latency_irq",   32'(irq),      32'd1);
        tick(1);
        checkOutput("pop_valid", 32'(ev_valid), 32'd0);
        checkOutput("pop_irq",   32'(irq),      32'd0);
        checkOutput("pop_queue", 32'(exp_q.size()), 32'd0);

        $display("[TB] glitch rejection and 5-cycle pulse");
        applyStimulus(6'b000101, 1'b0);
        tick(2);
        applyStimulus(6'b000100, 1'b0);
        tick(10);
        checkOutput("glitch_stable", 32'(sens_stable), 32'b000100);
        checkOutput("glitch_valid",  32'(ev_valid),    32'd0);
        applyStimulus(6'b000101, 1'b1);
        tick(4);
        applyStimulus(6'b000100, 1'b1);
        tick(1);
        checkOutput("pulse_stable_high", 32'(sens_stable), 32'b000101);
        waitDrain("pulse_drain", 30);
        checkOutput("pulse_stable_low", 32'(sens_stable), 32'b000100);

        $display("[TB] simultaneous edges on channels 1 and 4");
        applyStimulus(6'b010110, 1'b1);
        waitDrain("dual_drain", 30);
        checkOutput("dual_stable", 32'(sens_stable), 32'b010110);

        $display("[TB] FIFO full, pending hold and overflow");
        doReset();
        ev_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(sens_in | NUM_CH'(1 << c), 1'b1);
            tick(8);
        end
        checkOutput("full_valid", 32'(ev_valid),    32'd1);
        checkOutput("full_head",  32'(ev_chan),     32'd0);
        checkOutput("full_ovf",   32'(ev_overflow), 32'd0);
        applyStimulus(6'b001111, 1'b0);
        tick(8);
        checkOutput("drop_ovf",    32'(ev_overflow), 32'd1);
        checkOutput("drop_stable", 32'(sens_stable), 32'b001111);
        ev_ready = 1'b1;
        waitDrain("full_drain", 40);
        checkOutput("drain_ovf_kept", 32'(ev_overflow), 32'd1);
        checkOutput("drain_irq",      32'(irq),         32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", 32'(ev_overflow), 32'd0);
        checkOutput("ovf_irq",     32'(irq),         32'd0);

        $display("[TB] head stability under backpressure, timestamp wrap");
        ev_ready = 1'b0;
        applyStimulus(6'b101111, 1'b1);
        tick(8);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            checkOutput("hold_valid", 32'(ev_valid), 32'd1);
            checkOutput("hold_chan",  32'(ev_chan),  32'(exp_q[0].chan));
            checkOutput("hold_rise",  32'(ev_rise),  32'(exp_q[0].rise));
            checkOutput("hold_ts",    32'(ev_ts),    32'(exp_q[0].ts));
        end
        ev_ready = 1'b1;
        waitDrain("hold_drain", 20);
        for (int k = 0; k < 300 && tb_ts != 8'd252; k++) tick(1);
        applyStimulus(6'b001111, 1'b1);
        checkOutput("wrap_expect_ts", 32'(exp_q[0].ts), 32'd2);
        waitDrain("wrap_drain", 30);

        $display("[TB] reset with queued and pending events");
        doReset();
        ev_ready = 1'b0;
        applyStimulus(6'b001111, 1'b0);
        tick(9);
        checkOutput("pre_reset_valid",  32'(ev_valid),    32'd1);
        checkOutput("pre_reset_stable", 32'(sens_stable), 32'b001111);
        aresetn = 1'b0;
        tick(1);
        checkOutput("mid_reset_valid",  32'(ev_valid),    32'd0);
        checkOutput("mid_reset_stable", 32'(sens_stable), 32'd0);
        checkOutput("mid_reset_ovf",    32'(ev_overflow), 32'd0);
        checkOutput("mid_reset_irq",    32'(irq),         32'd0);
        sens_in = '0;
        tick(1);
        aresetn  = 1'b1;
        ev_ready = 1'b1;
        tick(15);
        checkOutput("post_reset_valid",  32'(ev_valid),    32'd0);
        checkOutput("post_reset_stable", 32'(sens_stable), 32'd0);
        checkOutput("post_reset_queue",  32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
